dds_gen: RTL and testbench

Parametrised direct digital synthesis generator, the next generation of the team's DDS block, feeding the DAC datapath.
- Wide phase accumulator with phase offset, truncated to a lookup address.
- Selectable waveform: sine, sawtooth, triangle or square.
- Frequency, phase and mode are loaded through a valid/ready configuration handshake. Updates are applied either immediately or phase-coherently at the next accumulator wrap.

---
 rtl/dds_pkg.sv | 26 ++
 rtl/dds_sine_lut.sv | 40 ++++
 rtl/dds_gen.sv | 165 ++++++++++++++++
 tb/tb_dds_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS generator: waveform modes, default widths,
// midscale helper and dither LFSR constants.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  localparam int DDS_ACC_W  = 32;
  localparam int DDS_ADDR_W = 9;
  localparam int DDS_DATA_W = 12;

  // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10 of a left-shifting register
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam real DDS_PI = 3.141592653589793;

  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Sine lookup with a registered read (1 cycle); table contents are computed at elaboration.
// Output register loads only when en_i is high, otherwise it holds.
module dds_sine_lut
  import dds_pkg::*;
#(
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DATA_W = DDS_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] dat_o
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam int  MID   = midscale(DATA_W);
  localparam real AMP   = real'(MID - 1);

  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] dat_q;

  // Round half away from zero so the table is symmetric about midscale
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real S = AMP * $sin(2.0 * DDS_PI * real'(i) / real'(DEPTH));
    localparam int  R = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    assign rom[i] = DATA_W'(MID + R);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q <= DATA_W'(MID);
    end else if (en_i) begin
      dat_q <= rom[addr_i];
    end
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/dds_gen.sv
// DDS generator: phase accumulator -> address stage -> waveform stage, latency 2 from acc to dout.
// cfg_ready drops while a wrap-deferred update is pending; DDS_DITHER_EN adds LFSR dither before truncation.
module dds_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = DDS_ACC_W,
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DATA_W = DDS_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [ADDR_W-1:0] cfg_pword,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_at_wrap,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              wrap_pulse
);

  localparam int SHIFT = DATA_W - ADDR_W;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_eff;
  logic [ACC_W:0]    sum;
  logic              carry;

  logic [ACC_W-1:0]  fword_q, sh_fword_q;
  logic [ADDR_W-1:0] pword_q, sh_pword_q;
  mode_e             mode_q, sh_mode_q;
  logic              pending_q, apply_q;
  logic              cfg_fire, activate;

  logic [ADDR_W-1:0] addr_q, addr_d;
  mode_e             mode1_q, mode2_q;
  logic              v1_q, v2_q, wrap_q;
  logic [ADDR_W-2:0] tri_r;
  logic [DATA_W-1:0] wave_q, wave_d, lut_dat;

  assign sum      = {1'b0, acc_q} + {1'b0, fword_q};
  assign carry    = sum[ACC_W];
  assign cfg_ready = ~pending_q;
  assign cfg_fire = cfg_valid & ~pending_q;
  // A deferred update lands on the same edge that wraps (or clears) the accumulator
  assign activate = apply_q | (pending_q & (sync_clr | (en & carry)));

  always_comb begin
    acc_d = acc_q;
    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      fword_q    <= '0;
      pword_q    <= '0;
      mode_q     <= MODE_SINE;
      sh_fword_q <= '0;
      sh_pword_q <= '0;
      sh_mode_q  <= MODE_SINE;
      pending_q  <= 1'b0;
      apply_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      apply_q <= cfg_fire & ~cfg_at_wrap;
      if (cfg_fire) begin
        sh_fword_q <= cfg_fword;
        sh_pword_q <= cfg_pword;
        sh_mode_q  <= mode_e'(cfg_mode);
      end
      if (activate) begin
        fword_q <= sh_fword_q;
        pword_q <= sh_pword_q;
        mode_q  <= sh_mode_q;
      end
      if (pending_q) begin
        pending_q <= ~activate;
      end else begin
        pending_q <= cfg_fire & cfg_at_wrap;
      end
    end
  end

`ifdef DDS_DITHER_EN
  localparam int DITH_W = (ACC_W - ADDR_W < 16) ? (ACC_W - ADDR_W) : 16;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign acc_eff = acc_q + ACC_W'(lfsr_q[DITH_W-1:0]);
`else
  assign acc_eff = acc_q;
`endif

  assign addr_d = ADDR_W'(acc_eff >> (ACC_W - ADDR_W)) + pword_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      mode1_q <= MODE_SINE;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      mode1_q <= mode_q;
      v1_q    <= en;
      v2_q    <= v1_q;
      wrap_q  <= en & ~sync_clr & carry;
    end
  end

  assign tri_r = addr_q[ADDR_W-2:0] ^ {(ADDR_W-1){addr_q[ADDR_W-1]}};

  always_comb begin
    wave_d = wave_q;
    unique case (mode1_q)
      MODE_SAW: wave_d = DATA_W'(addr_q) << SHIFT;
      MODE_TRI: wave_d = DATA_W'({tri_r, 1'b0}) << SHIFT;
      MODE_SQR: wave_d = addr_q[ADDR_W-1] ? '0 : '1;
      default:  wave_d = wave_q;
    endcase
  end

  dds_sine_lut #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sine_lut (
    .clk_i (clk),
    .rst_ni(reset_n),
    .en_i  (v1_q),
    .addr_i(addr_q),
    .dat_o (lut_dat)
  );

  // Stage-2 state only advances for valid samples so dout holds between them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wave_q  <= DATA_W'(midscale(DATA_W));
      mode2_q <= MODE_SINE;
    end else if (v1_q) begin
      wave_q  <= wave_d;
      mode2_q <= mode1_q;
    end
  end

  assign dout       = (mode2_q == MODE_SINE) ? lut_dat : wave_q;
  assign dout_valid = v2_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_dds_gen.sv
// Bench for dds_gen: directed waveform/config scenarios plus random traffic against a reference model.
module tb_dds_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, sync_clr, cfg_valid, cfg_at_wrap;
  logic        cfg_ready, dout_valid, wrap_pulse;
  logic [31:0] cfg_fword;
  logic [8:0]  cfg_pword;
  logic [1:0]  cfg_mode;
  logic [11:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .sync_clr   (sync_clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_fword  (cfg_fword),
    .cfg_pword  (cfg_pword),
    .cfg_mode   (cfg_mode),
    .cfg_at_wrap(cfg_at_wrap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .wrap_pulse (wrap_pulse)
  );

  // Reference model state: architectural values, not RTL registers
  logic [31:0] m_acc, m_fw, m_sfw;
  int          m_pw, m_spw, m_mode, m_smode;
  bit          m_pend, m_apply;
  bit          s1_v;
  int          s1_val;
  int          m_dout;
  bit          m_vld, m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sine_ref(input int a);
    real s;
    s = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 512.0);
    if (s >= 0.0) return 2048 + $rtoi(s + 0.5);
    else return 2048 - $rtoi(0.5 - s);
  endfunction

  function automatic int wave_ref(input int a, input int mode);
    case (mode)
      0: return sine_ref(a);
      1: return a * 8;
      2: return ((a < 256) ? a : 511 - a) * 16;
      default: return (a < 256) ? 4095 : 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_fw = 0; m_sfw = 0;
    m_pw = 0; m_spw = 0; m_mode = 0; m_smode = 0;
    m_pend = 0; m_apply = 0;
    s1_v = 0; s1_val = 0;
    m_dout = 2048; m_vld = 0; m_wrap = 0;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  function automatic void model_step();
    logic [32:0] s;
    bit ovf, fire, act;
    s    = {1'b0, m_acc} + {1'b0, m_fw};
    ovf  = s[32];
    fire = cfg_valid && !m_pend;
    act  = m_apply || (m_pend && (sync_clr || (en && ovf)));
    if (s1_v) m_dout = s1_val;
    m_vld  = s1_v;
    s1_v   = en;
    s1_val = wave_ref((int'(m_acc[31:23]) + m_pw) % 512, m_mode);
    m_wrap = en && !sync_clr && ovf;
    if (sync_clr) m_acc = 0;
    else if (en) m_acc = s[31:0];
    m_pend  = m_pend ? !act : (fire && cfg_at_wrap);
    m_apply = fire && !cfg_at_wrap;
    if (act) begin
      m_fw = m_sfw; m_pw = m_spw; m_mode = m_smode;
    end
    if (fire) begin
      m_sfw = cfg_fword; m_spw = int'(cfg_pword); m_smode = int'(cfg_mode);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("dout", int'(dout), m_dout);
    chk("dout_valid", int'(dout_valid), int'(m_vld));
    chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
  endtask

  task automatic start(input logic [31:0] fw, input int pw, input int mode);
    en = 0; sync_clr = 1; cfg_valid = 1; cfg_at_wrap = 0;
    cfg_fword = fw; cfg_pword = 9'(pw); cfg_mode = 2'(mode);
    tick();
    sync_clr = 0; cfg_valid = 0;
    tick();
    en = 1;
  endtask

  initial begin
    int sq[4];
    int wraps;
    bit found;
    sq = '{2048, 4095, 2048, 1};

    reset_n = 0; en = 0; sync_clr = 0; cfg_valid = 0; cfg_at_wrap = 0;
    cfg_fword = 0; cfg_pword = 0; cfg_mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 2048);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_wrap", int'(wrap_pulse), 0);
    reset_n = 1;
    tick();
    chk("rel_dout", int'(dout), 2048);

    // Saw at one LUT step per sample
    start(32'h0080_0000, 0, 1);
    tick(); chk("vld_lat1", int'(dout_valid), 0);
    tick(); chk("vld_lat2", int'(dout_valid), 1);
    chk("saw_first", int'(dout), 0);
    tick(); chk("saw_second", int'(dout), 8);
    wraps = 0;
    for (int i = 4; i <= 1024; i++) begin
      tick();
      if (wrap_pulse) wraps++;
      if (i == 513) chk("saw_top", int'(dout), 4088);
      if (i == 514) chk("saw_rollover", int'(dout), 0);
    end
    chk("saw_wrap_count", wraps, 2);

    // Sine in quarter-cycle steps
    start(32'h4000_0000, 0, 0);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      chk("sine_quarter", int'(dout), sq[i % 4]);
      tick();
    end

    // Static phase offsets
    start(32'h0, 128, 0);
    tick(); tick(); chk("pw128_sine", int'(dout), 4095);
    tick(); chk("pw128_hold", int'(dout), 4095);
    start(32'h0, 384, 0);
    tick(); tick(); chk("pw384_sine", int'(dout), 1);
    start(32'h0, 256, 3);
    tick(); tick(); chk("pw256_sqr", int'(dout), 0);

    // Phase-coherent frequency change requested half way through a cycle
    start(32'h0080_0000, 0, 1);
    repeat (256) tick();
    cfg_valid = 1; cfg_at_wrap = 1; cfg_fword = 32'h0100_0000; cfg_pword = 0; cfg_mode = 1;
    tick();
    chk("coh_ready_low", int'(cfg_ready), 0);
    cfg_at_wrap = 0; cfg_fword = 32'h0010_0000;
    tick();
    cfg_valid = 0;
    chk("coh_ignored", int'(cfg_ready), 0);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (wrap_pulse) found = 1;
    end
    chk("coh_wrap_seen", int'(found), 1);
    chk("coh_ready_back", int'(cfg_ready), 1);
    chk("coh_old_step", int'(dout), 4080);
    tick(); chk("coh_last_old", int'(dout), 4088);
    tick(); chk("coh_zero", int'(dout), 0);
    tick(); chk("coh_new_step1", int'(dout), 16);
    tick(); chk("coh_new_step2", int'(dout), 32);

    // sync_clr releases a pending update on the clearing edge
    cfg_valid = 1; cfg_at_wrap = 1; cfg_fword = 32'h0080_0000; cfg_pword = 0; cfg_mode = 2;
    tick();
    cfg_valid = 0;
    repeat (5) tick();
    chk("clr_pending", int'(cfg_ready), 0);
    sync_clr = 1;
    tick();
    sync_clr = 0;
    chk("clr_no_wrap", int'(wrap_pulse), 0);
    chk("clr_applied", int'(cfg_ready), 1);
    tick();
    tick(); chk("clr_tri0", int'(dout), 0);
    tick(); chk("clr_tri1", int'(dout), 16);
    tick(); chk("clr_tri2", int'(dout), 32);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 7) != 0);
      sync_clr    = ($urandom_range(0, 63) == 0);
      cfg_valid   = ($urandom_range(0, 15) == 0);
      cfg_at_wrap = 1'($urandom_range(0, 1));
      cfg_fword   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) >> 6);
      cfg_pword   = 9'($urandom_range(0, 511));
      cfg_mode    = 2'($urandom_range(0, 3));
      tick();
    end

    // Reset in the middle of a pending update
    en = 0; cfg_valid = 0; sync_clr = 1;
    tick();
    sync_clr = 0;
    cfg_valid = 1; cfg_at_wrap = 1; cfg_fword = 32'h0000_1000; cfg_pword = 0; cfg_mode = 1;
    tick();
    cfg_valid = 0;
    chk("mid_pending", int'(cfg_ready), 0);
    en = 1;
    repeat (3) tick();
    #2 reset_n = 0;
    #1;
    chk("mid_rst_dout", int'(dout), 2048);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_ready", int'(cfg_ready), 1);
    chk("mid_rst_wrap", int'(wrap_pulse), 0);
    model_reset();
    en = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    start(32'h4000_0000, 0, 0);
    tick(); tick(); chk("post_rst_sine0", int'(dout), 2048);
    tick(); chk("post_rst_sine1", int'(dout), 4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
